// File: rtl/serial_adder.sv
// serial_adder -- bit-serial ripple adder.
//
// Adds two WIDTH-bit unsigned operands LSB-first, one bit per clock, using a
// single full-adder slice made of two ha half-adders and an OR for the carry.
// A one-cycle Start strobe loads the operands. The result appears with a
// one-cycle Done pulse WIDTH+1 edges later.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   Start  load request; accepted in IDLE or DONE, ignored in RUN
//   A, B   WIDTH-bit operands, captured on an accepted Start
//   Cin    carry-in, captured on an accepted Start
//   Busy   high while the addition is in progress
//   Done   one-cycle pulse; Sum/Cout valid while high
//   Sum    A + B + Cin mod 2^WIDTH (held until the next accepted Start)
//   Cout   carry out of bit WIDTH-1 (updated only on entry to DONE)

// Half adder used as the building block of the full-adder slice.
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, sum_shift;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             sum1, carry1, s, carry2, carry_next;
  logic             accept, last_bit;

  // Full-adder slice: the first ha adds the two operand bits, the second
  // folds in the stored carry; either half producing a carry sets it.
  ha u_ha0 (.a(sa[0]), .b(sb[0]), .s(sum1), .c(carry1));
  ha u_ha1 (.a(sum1),  .b(c),     .s(s),    .c(carry2));

  assign carry_next = carry1 | carry2;

  // The result register doubles as the shift-in register: each new sum bit
  // enters at the top, so after WIDTH shifts bit 0 sits at the bottom.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = s;
    end else begin : g_sum_wn
      assign sum_shift = {s, Sum[WIDTH-1:1]};
    end
  endgenerate

  assign accept   = Start && (state != RUN);
  assign last_bit = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A Start seen in DONE chains straight into a new RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = Start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs. Busy/Done are registered from
  // the next state so they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      Sum  <= '0;
      Cout <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Busy <= (state_next == RUN);
      Done <= (state_next == DONE);
      if (accept) begin
        sa  <= A;
        sb  <= B;
        c   <= Cin;
        cnt <= '0;
      end else if (state == RUN) begin
        c   <= carry_next;
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        Sum <= sum_shift;
        cnt <= cnt + CW'(1);
        // The carry out of the final bit is the overall carry-out.
        if (last_bit) begin
          Cout <= carry_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- directed bench for serial_adder.
//
// Drives a WIDTH=8 instance through a linear sequence of operations and a
// WIDTH=1 instance through a single addition. Expected results for the
// 8-bit instance are pushed to a queue when Start is accepted and popped
// when Done is seen.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clkEn = 1'b0;
  logic         rst = 1'b0;

  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Busy, Done, Cout;
  logic [W-1:0] Sum;

  logic         Start1 = 1'b0;
  logic [0:0]   A1 = '0;
  logic [0:0]   B1 = '0;
  logic         Cin1 = 1'b0;
  logic         Busy1, Done1, Cout1;
  logic [0:0]   Sum1;

  int compared = 0;
  int mismatched = 0;

  // Scoreboard entries are {cout, sum}.
  logic [W:0] sbQueue[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Cout(Cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .Start(Start1), .A(A1), .B(B1), .Cin(Cin1),
    .Busy(Busy1), .Done(Done1), .Sum(Sum1), .Cout(Cout1)
  );

  // Clock can be held stopped so reset can be shown to act without an edge.
  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  // Hard stop in case the sequence ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load operands on the next rising edge and record the expected result.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    A = a;
    B = b;
    Cin = cin;
    Start = 1'b1;
    sbQueue.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Wait (bounded) for Done, checking latency, Busy coverage and the result.
  task automatic waitDone(input string tag, input int expLat);
    int cycles = 0;
    int busyCnt = 0;
    logic [W:0] exp;
    while (Done !== 1'b1 && cycles < 40) begin
      if (Busy === 1'b1) busyCnt++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " latency"}, cycles, expLat);
    checkOutput({tag, " busy cycles"}, busyCnt, expLat);
    checkOutput({tag, " busy in done"}, {31'b0, Busy}, 32'd0);
    checkOutput({tag, " queue nonempty"}, {31'b0, (sbQueue.size() > 0)}, 32'd1);
    if (sbQueue.size() > 0) begin
      exp = sbQueue.pop_front();
      checkOutput({tag, " sum"}, {24'b0, Sum}, {24'b0, exp[W-1:0]});
      checkOutput({tag, " cout"}, {31'b0, Cout}, {31'b0, exp[W]});
    end
  endtask

  initial begin
    logic [1:0] exp1;

    // Reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    checkOutput("reset busy", {31'b0, Busy}, 32'd0);
    checkOutput("reset done", {31'b0, Done}, 32'd0);
    checkOutput("reset sum", {24'b0, Sum}, 32'd0);
    checkOutput("reset cout", {31'b0, Cout}, 32'd0);
    checkOutput("reset w1 sum", {31'b0, Sum1}, 32'd0);
    #2 rst = 1'b0;
    #1 clkEn = 1'b1;

    // Basic addition, then result held after Done drops.
    applyStimulus(8'h0F, 8'h01, 1'b0);
    waitDone("0F+01", W);
    @(negedge clk);
    checkOutput("0F+01 done drop", {31'b0, Done}, 32'd0);
    checkOutput("0F+01 held sum", {24'b0, Sum}, 32'h10);
    checkOutput("0F+01 held cout", {31'b0, Cout}, 32'd0);
    checkOutput("0F+01 idle busy", {31'b0, Busy}, 32'd0);

    // Wrap and carry cases.
    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone("FF+01", W);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    waitDone("FF+FF+1", W);

    // Start during RUN is ignored; Start held into DONE chains a new add.
    applyStimulus(8'h03, 8'h04, 1'b0);
    repeat (3) @(negedge clk);
    A = 8'h55;
    B = 8'h22;
    Cin = 1'b0;
    Start = 1'b1;
    waitDone("03+04", W - 3);
    sbQueue.push_back({1'b0, 8'h55} + {1'b0, 8'h22});
    @(negedge clk);
    Start = 1'b0;
    checkOutput("chain done drop", {31'b0, Done}, 32'd0);
    waitDone("55+22", W);

    // Reset in the middle of a run aborts it asynchronously.
    applyStimulus(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sbQueue.delete();
    checkOutput("abort busy", {31'b0, Busy}, 32'd0);
    checkOutput("abort done", {31'b0, Done}, 32'd0);
    checkOutput("abort sum", {24'b0, Sum}, 32'd0);
    checkOutput("abort cout", {31'b0, Cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h01, 8'h01, 1'b0);
    waitDone("01+01", W);

    // WIDTH=1 instance: Done two edges after acceptance.
    @(negedge clk);
    A1 = 1'b1;
    B1 = 1'b1;
    Cin1 = 1'b1;
    exp1 = {1'b0, A1} + {1'b0, B1} + {1'b0, Cin1};
    Start1 = 1'b1;
    @(negedge clk);
    Start1 = 1'b0;
    checkOutput("w1 busy", {31'b0, Busy1}, 32'd1);
    checkOutput("w1 early done", {31'b0, Done1}, 32'd0);
    @(negedge clk);
    checkOutput("w1 done", {31'b0, Done1}, 32'd1);
    checkOutput("w1 busy in done", {31'b0, Busy1}, 32'd0);
    checkOutput("w1 sum", {31'b0, Sum1}, {31'b0, exp1[0]});
    checkOutput("w1 cout", {31'b0, Cout1}, {31'b0, exp1[1]});
    @(negedge clk);
    checkOutput("w1 done drop", {31'b0, Done1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands LSB-first, one bit per clock, using a single full-adder slice built from two `ha` half-adder instances plus an OR for the carry. It sits directly downstream of `ha` and is the first sequential consumer of it. It trades WIDTH cycles of latency for one bit-slice of area. Operands are loaded with a start strobe, and the result is reported with a one-cycle Done pulse.

## Interface

- WIDTH, 8: operand and sum width in bits; legal range ≥ 1.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high; returns all state to reset values immediately.
- Start  input  1  load request; sampled on rising clk.
- A  input  WIDTH  operand A; captured only on an accepted Start.
- B  input  WIDTH  operand B; captured only on an accepted Start.
- Cin  input  1  carry-in; captured only on an accepted Start.
- Busy  output  1  high while the state machine is in RUN.
- Done  output  1  one-cycle pulse; Sum and Cout are valid while it is high.
- Sum  output  WIDTH  result, A + B + Cin mod 2^WIDTH.
- Cout  output  1  carry out of bit WIDTH-1.

## Operation

- States: IDLE, RUN, DONE. Reset state is IDLE.
- Internal state:
  - shift registers SA and SB, each WIDTH bits;
  - carry register C, 1 bit;
  - bit counter CNT, width clog2(WIDTH+1);
  - result register Sum, which doubles as the shift-in register.
- Start is accepted in IDLE or DONE. Start is ignored in RUN, with no effect on the operation in flight.
- On acceptance:
  - SA←A, SB←B, C←Cin, CNT←0;
  - next state is RUN.
- On each RUN edge:
  - s = SA[0]^SB[0]^C, computed by ha(SA[0],SB[0]) followed by ha(sum1,C);
  - C ← carry1 | carry2;
  - SA and SB shift right by 1;
  - Sum ← {s, Sum[WIDTH-1:1]};
  - CNT increments.
- When CNT reaches WIDTH-1 on a RUN edge, that edge processes the last bit and the next state is DONE.
- DONE lasts one cycle:
  - Done=1, Cout=C;
  - next state is IDLE, or RUN if Start=1 in that cycle.
- Sum and Cout hold their final values through DONE and IDLE until the next accepted Start.
  - Sum contents during RUN are partial and are not valid.
  - Cout updates only on entry to DONE.
- Arithmetic is unsigned. Overflow wraps mod 2^WIDTH, with the overflow bit reported on Cout.
- A, B and Cin are don't-care except on the edge where Start is accepted.
- Reset mid-operation aborts the addition with no partial result retained. The next Start begins a fresh operation.

## Timing

- Reset values: Busy=0, Done=0, Sum=0, Cout=0, state IDLE, C=0, CNT=0, SA=SB=0.
- Let the accepting edge be E0:
  - Busy=1 from after E0 through after E(WIDTH-1);
  - RUN edges are E1..E(WIDTH);
  - Done=1 and Busy=0 in the cycle after E(WIDTH).
- Latency: WIDTH+1 edges from the accepting edge to the Done pulse.
- Throughput with back-to-back Start: one result per WIDTH+1 cycles.
- Done is high for exactly one cycle per completed operation.
- Done and Busy are never high together.
- WIDTH=1: one RUN edge; Done is asserted 2 edges after acceptance.
- Start in DONE: new operands are loaded on that edge. Done still pulses for the completing result and drops on the next cycle. Sum and Cout start changing after that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- rst takes effect without a clock edge. After deassertion, the first Start is honoured on the next rising edge.

## Test plan

- Reset: assert rst mid-cycle with clk stopped → Busy=0, Done=0, Sum=8'h00, Cout=0 immediately.
- WIDTH=8, A=8'h0F, B=8'h01, Cin=0, Start for one cycle:
  - Busy high for 8 cycles, then Done for one cycle;
  - Sum=8'h10, Cout=0;
  - values held after Done drops.
- Wrap and carry cases:
  - A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1;
  - A=8'hFF, B=8'hFF, Cin=1 → Sum=8'hFF, Cout=1.
- Start during RUN with A=8'h55, B=8'h22 while an operation of 8'h03+8'h04 runs:
  - second Start ignored; Sum=8'h07, Cout=0;
  - Start held high into the DONE cycle loads 8'h55+8'h22 → Sum=8'h77, Cout=0, with the Done pulse 9 edges after the DONE cycle.
- Reset at the 4th RUN cycle of 8'hAA+8'h55:
  - all outputs return to 0 asynchronously, state IDLE;
  - a following Start with 8'h01+8'h01 yields Sum=8'h02, Cout=0 with normal latency.
- WIDTH=1 build: A=1, B=1, Cin=1 → Done 2 edges after acceptance, Sum=1, Cout=1.
